// File: rtl/arc_microsequencer.sv
// -----------------------------------------------------------------------------
// arc_microsequencer
//
// Purpose
//   Next-address logic and control-store address register (CSAR) for the ARC
//   microprogrammed datapath. Each clock the sequencer looks at the COND and
//   JUMPADDR fields of the current microinstruction, the PSR condition codes
//   and IR[13]. From these it picks the next control-store address:
//     - increment
//     - conditional jump
//     - unconditional jump
//     - DECODE dispatch on the opcode fields of the IR
//   The registered CSAR feeds the microcode store. The store latches it on the
//   following negedge, so the design delivers one microinstruction per clock.
//
// Configuration macro
//   MICROSEQUENCER_MEMWAIT_EN
//     Defined   : adds the WAIT state. The memory handshake
//                 (MemAccess_In / MemReady_In) stalls CSAR while a main-memory
//                 transfer is outstanding, and Stall_Out reports the stall.
//     Undefined : the sequencer is always in RUN and CSAR advances every
//                 clock. The handshake inputs are ignored and Stall_Out is
//                 always 0.
//
// Ports
//   MICROSEQUENCER_CLOCK_50           in   1   system clock, CSAR updates on rising edge
//   MICROSEQUENCER_ResetInHigh_In     in   1   synchronous active-high reset
//   MICROSEQUENCER_Condition_InBus    in   3   COND field of the MIR
//   MICROSEQUENCER_JumpAddress_InBus  in  11   JUMPADDR field of the MIR
//   MICROSEQUENCER_IR_InBus           in  32   instruction register
//   MICROSEQUENCER_FlagN/Z/V/C_In     in   1   PSR condition codes
//   MICROSEQUENCER_MemAccess_In       in   1   RD or WR in current microinstruction
//   MICROSEQUENCER_MemReady_In        in   1   main memory transfer complete
//   MICROSEQUENCER_CSAddress_OutBus   out 11   CSAR to the microcode store
//   MICROSEQUENCER_Stall_Out          out  1   CSAR held waiting for memory
//   MICROSEQUENCER_Decode_Out         out  1   one cycle after a DECODE dispatch
// -----------------------------------------------------------------------------
module arc_microsequencer #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32
) (
    input  logic                             MICROSEQUENCER_CLOCK_50,
    input  logic                             MICROSEQUENCER_ResetInHigh_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   MICROSEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_JumpAddress_InBus,
    input  logic [DATAWIDTH_IR-1:0]          MICROSEQUENCER_IR_InBus,
    input  logic                             MICROSEQUENCER_FlagN_In,
    input  logic                             MICROSEQUENCER_FlagZ_In,
    input  logic                             MICROSEQUENCER_FlagV_In,
    input  logic                             MICROSEQUENCER_FlagC_In,
    input  logic                             MICROSEQUENCER_MemAccess_In,
    input  logic                             MICROSEQUENCER_MemReady_In,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_CSAddress_OutBus,
    output logic                             MICROSEQUENCER_Stall_Out,
    output logic                             MICROSEQUENCER_Decode_Out
);

    // COND field encodings of the microinstruction
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_INC  = 3'b000;
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_N    = 3'b001;
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_Z    = 3'b010;
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_V    = 3'b011;
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_C    = 3'b100;
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_IR13 = 3'b101;
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_JUMP = 3'b110;
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_DEC  = 3'b111;

`ifdef MICROSEQUENCER_MEMWAIT_EN
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0
    } state_t;
`endif

    state_t                           state_q;
    logic [DATAWIDTH_JUMPADDRESS-1:0] csar_q;
    logic                             stall_q;
    logic                             decode_q;

    logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr_d;
    logic [DATAWIDTH_JUMPADDRESS-1:0] csar_inc_s;
    logic [10:0]                      decode_addr_s;
    logic                             take_jump_s;
    logic                             is_decode_s;

    // Natural wrap of the adder gives the modulo-2^11 increment (2047 -> 0).
    assign csar_inc_s = csar_q + DATAWIDTH_JUMPADDRESS'(1'b1);

    // DECODE dispatch target: 1, op (IR[31:30]), op3 (IR[24:19]), 00.
    // The two low zero bits leave four microwords per instruction entry.
    assign decode_addr_s = {1'b1,
                            MICROSEQUENCER_IR_InBus[31:30],
                            MICROSEQUENCER_IR_InBus[24:19],
                            2'b00};

    // Next-address mux. It uses only the registered CSAR and the inputs, so
    // there is no combinational path from the output back to itself.
    always_comb begin
        take_jump_s = 1'b0;
        is_decode_s = 1'b0;
        next_addr_d = csar_inc_s;
        case (MICROSEQUENCER_Condition_InBus)
            COND_INC:  take_jump_s = 1'b0;
            COND_N:    take_jump_s = MICROSEQUENCER_FlagN_In;
            COND_Z:    take_jump_s = MICROSEQUENCER_FlagZ_In;
            COND_V:    take_jump_s = MICROSEQUENCER_FlagV_In;
            COND_C:    take_jump_s = MICROSEQUENCER_FlagC_In;
            COND_IR13: take_jump_s = MICROSEQUENCER_IR_InBus[13];
            COND_JUMP: take_jump_s = 1'b1;
            COND_DEC:  is_decode_s = 1'b1;
            default:   take_jump_s = 1'b0;
        endcase
        if (is_decode_s) begin
            next_addr_d = DATAWIDTH_JUMPADDRESS'(decode_addr_s);
        end else if (take_jump_s) begin
            next_addr_d = MICROSEQUENCER_JumpAddress_InBus;
        end else begin
            next_addr_d = csar_inc_s;
        end
    end

    // Sequencer FSM: owns CSAR, the stall flag and the decode strobe.
    // Flags and IR only matter on the edge that actually advances CSAR.
    // While in WAIT the mux output is ignored, and on leaving WAIT the
    // still-held MIR fields produce the next address.
    always_ff @(posedge MICROSEQUENCER_CLOCK_50) begin
        if (MICROSEQUENCER_ResetInHigh_In) begin
            state_q  <= ST_RUN;
            csar_q   <= {DATAWIDTH_JUMPADDRESS{1'b0}};
            stall_q  <= 1'b0;
            decode_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
`ifdef MICROSEQUENCER_MEMWAIT_EN
                    if (MICROSEQUENCER_MemAccess_In && !MICROSEQUENCER_MemReady_In) begin
                        state_q  <= ST_WAIT;
                        stall_q  <= 1'b1;
                        decode_q <= 1'b0;
                    end else begin
                        state_q  <= ST_RUN;
                        csar_q   <= next_addr_d;
                        stall_q  <= 1'b0;
                        decode_q <= is_decode_s;
                    end
`else
                    state_q  <= ST_RUN;
                    csar_q   <= next_addr_d;
                    stall_q  <= 1'b0;
                    decode_q <= is_decode_s;
`endif
                end
`ifdef MICROSEQUENCER_MEMWAIT_EN
                ST_WAIT: begin
                    if (MICROSEQUENCER_MemReady_In) begin
                        state_q  <= ST_RUN;
                        csar_q   <= next_addr_d;
                        stall_q  <= 1'b0;
                        decode_q <= is_decode_s;
                    end else begin
                        state_q  <= ST_WAIT;
                        stall_q  <= 1'b1;
                        decode_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    // Unreachable encoding: return to RUN with CSAR held.
                    state_q  <= ST_RUN;
                    stall_q  <= 1'b0;
                    decode_q <= 1'b0;
                end
            endcase
        end
    end

    assign MICROSEQUENCER_CSAddress_OutBus = csar_q;
    assign MICROSEQUENCER_Stall_Out        = stall_q;
    assign MICROSEQUENCER_Decode_Out       = decode_q;

    // IR bits outside the op/op3/bit-13 fields are not used for sequencing.
    // Without the memory-wait feature, the handshake inputs are not used either.
    logic unused_inputs_s;
`ifdef MICROSEQUENCER_MEMWAIT_EN
    assign unused_inputs_s = ^{MICROSEQUENCER_IR_InBus[29:25],
                               MICROSEQUENCER_IR_InBus[18:14],
                               MICROSEQUENCER_IR_InBus[12:0]};
`else
    assign unused_inputs_s = ^{MICROSEQUENCER_IR_InBus[29:25],
                               MICROSEQUENCER_IR_InBus[18:14],
                               MICROSEQUENCER_IR_InBus[12:0],
                               MICROSEQUENCER_MemAccess_In,
                               MICROSEQUENCER_MemReady_In};
`endif

endmodule

// File: tb/tb_arc_microsequencer.sv
// Directed testbench for arc_microsequencer. Inputs change after each rising
// edge; outputs are checked 1 time unit after the edge they depend on.
module tb_arc_microsequencer;

    logic        clk;
    logic        rst;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic [31:0] ir;
    logic        fn, fz, fv, fc;
    logic        mem_access;
    logic        mem_ready;
    logic [10:0] csa;
    logic        stall;
    logic        decode;

    int n_checks;
    int n_fail;

    arc_microsequencer dut (
        .MICROSEQUENCER_CLOCK_50          (clk),
        .MICROSEQUENCER_ResetInHigh_In    (rst),
        .MICROSEQUENCER_Condition_InBus   (cond),
        .MICROSEQUENCER_JumpAddress_InBus (jump),
        .MICROSEQUENCER_IR_InBus          (ir),
        .MICROSEQUENCER_FlagN_In          (fn),
        .MICROSEQUENCER_FlagZ_In          (fz),
        .MICROSEQUENCER_FlagV_In          (fv),
        .MICROSEQUENCER_FlagC_In          (fc),
        .MICROSEQUENCER_MemAccess_In      (mem_access),
        .MICROSEQUENCER_MemReady_In       (mem_ready),
        .MICROSEQUENCER_CSAddress_OutBus  (csa),
        .MICROSEQUENCER_Stall_Out         (stall),
        .MICROSEQUENCER_Decode_Out        (decode)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a microinstruction, clock once, check CSAR, stall and decode
    task automatic step(input string tag, input logic [2:0] c, input logic [10:0] j,
                        input logic [10:0] exp_csa, input logic exp_stall, input logic exp_dec);
        cond = c;
        jump = j;
        tick();
        check_eq({tag, "_csa"},    32'(csa),    32'(exp_csa));
        check_eq({tag, "_stall"},  32'(stall),  32'(exp_stall));
        check_eq({tag, "_decode"}, 32'(decode), 32'(exp_dec));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        cond       = 3'b000;
        jump       = 11'd0;
        ir         = 32'h0000_0000;
        fn         = 1'b0;
        fz         = 1'b0;
        fv         = 1'b0;
        fc         = 1'b0;
        mem_access = 1'b0;
        mem_ready  = 1'b0;

        // Reset held for two clocks
        tick();
        tick();
        check_eq("rst_csa",    32'(csa),    32'd0);
        check_eq("rst_stall",  32'(stall),  32'd0);
        check_eq("rst_decode", 32'(decode), 32'd0);

        // Increment sequence 0 -> 1 -> 2 -> 3
        rst = 1'b0;
        step("inc1", 3'b000, 11'd0, 11'd1, 1'b0, 1'b0);
        step("inc2", 3'b000, 11'd0, 11'd2, 1'b0, 1'b0);
        step("inc3", 3'b000, 11'd0, 11'd3, 1'b0, 1'b0);

        // Back to CSAR=1 for the DECODE test
        rst = 1'b1;
        tick();
        check_eq("rst2_csa", 32'(csa), 32'd0);
        rst = 1'b0;
        step("to1", 3'b000, 11'd0, 11'd1, 1'b0, 1'b0);

        // DECODE of 8A00_4002: op=10, IR[24:19]=000000 -> 1_10_000000_00 = 1536
        ir = 32'h8A00_4002;
        step("dec_a", 3'b111, 11'd0, 11'd1536, 1'b0, 1'b1);
        step("dec_a_next", 3'b000, 11'd0, 11'd1537, 1'b0, 1'b0);
        // DECODE with op3=010000 (IR[23]=1) -> 1_10_010000_00 = 1600
        ir = 32'h8A80_4002;
        step("dec_b", 3'b111, 11'd0, 11'd1600, 1'b0, 1'b1);

        // IR[13] conditional
        ir = 32'h0000_2000;
        step("ir13_take", 3'b101, 11'd1692, 11'd1692, 1'b0, 1'b0);
        ir = 32'h8A80_4002;
        step("dec_c", 3'b111, 11'd0, 11'd1600, 1'b0, 1'b1);
        step("ir13_fall", 3'b101, 11'd1692, 11'd1601, 1'b0, 1'b0);

        // N, V, C conditionals, taken and not taken; wrong flag must not jump
        fn = 1'b1;
        step("n_take", 3'b001, 11'd5, 11'd5, 1'b0, 1'b0);
        fn = 1'b0; fz = 1'b1;
        step("n_fall", 3'b001, 11'd9, 11'd6, 1'b0, 1'b0);
        fz = 1'b0; fv = 1'b1;
        step("v_take", 3'b011, 11'd100, 11'd100, 1'b0, 1'b0);
        fv = 1'b0;
        step("c_fall", 3'b100, 11'd7, 11'd101, 1'b0, 1'b0);
        fc = 1'b1;
        step("c_take", 3'b100, 11'd7, 11'd7, 1'b0, 1'b0);
        fc = 1'b0;

        // Z conditional and wrap of the increment at 2047
        fz = 1'b1;
        step("z_take", 3'b010, 11'h400, 11'h400, 1'b0, 1'b0);
        fz = 1'b0;
        step("jmp_2047", 3'b110, 11'd2047, 11'd2047, 1'b0, 1'b0);
        step("z_wrap", 3'b010, 11'h400, 11'd0, 1'b0, 1'b0);

        // Memory handshake from CSAR=0
        mem_access = 1'b1;
        mem_ready  = 1'b0;
`ifdef MICROSEQUENCER_MEMWAIT_EN
        step("wait1", 3'b000, 11'd0, 11'd0, 1'b1, 1'b0);
        step("wait2", 3'b000, 11'd0, 11'd0, 1'b1, 1'b0);
        step("wait3", 3'b000, 11'd0, 11'd0, 1'b1, 1'b0);
        mem_ready = 1'b1;
        step("wait_done", 3'b000, 11'd0, 11'd1, 1'b0, 1'b0);
        step("acc_rdy_run", 3'b000, 11'd0, 11'd2, 1'b0, 1'b0);
        mem_ready = 1'b0;
        step("wait_again", 3'b000, 11'd0, 11'd2, 1'b1, 1'b0);
`else
        step("nowait1", 3'b000, 11'd0, 11'd1, 1'b0, 1'b0);
        step("nowait2", 3'b000, 11'd0, 11'd2, 1'b0, 1'b0);
        step("nowait3", 3'b000, 11'd0, 11'd3, 1'b0, 1'b0);
        mem_ready = 1'b1;
        step("nowait4", 3'b000, 11'd0, 11'd4, 1'b0, 1'b0);
        step("acc_rdy_run", 3'b000, 11'd0, 11'd5, 1'b0, 1'b0);
        mem_ready = 1'b0;
        step("nowait6", 3'b000, 11'd0, 11'd6, 1'b0, 1'b0);
`endif

        // Reset while the handshake is pending overrides it
        rst = 1'b1;
        step("rst_wait", 3'b000, 11'd0, 11'd0, 1'b0, 1'b0);
        rst        = 1'b0;
        mem_access = 1'b0;
        step("post_rst_run", 3'b000, 11'd0, 11'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
